// File: rtl/pipeline_perf_monitor_pkg.sv
// pipeline_perf_monitor_pkg: shared FSM state type and default sizing for the perf monitor
package pipeline_perf_monitor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_MAX_CYCLES = 30;
    localparam int DEF_CNT_W      = 16;
endpackage

// File: rtl/perf_trace_fifo.sv
// perf_trace_fifo: sync FIFO; full/empty from the extra pointer MSB, simultaneous push+pop allowed when full
module perf_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int A = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [A:0]   wp, rp;
    logic         do_push, do_pop;
    assign empty_o = wp == rp;
    assign full_o  = (wp[A] != rp[A]) && (wp[A-1:0] == rp[A-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem[rp[A-1:0]];
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wp <= '0;
            rp <= '0;
        end else if (clr_i) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (A+1)'(do_push);
            rp <= rp + (A+1)'(do_pop);
        end
    always_ff @(posedge clk_i)
        if (do_push) mem[wp[A-1:0]] <= din_i;
endmodule

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: per-run cycle/stall/flush counters with auto-stop and a PC trace FIFO
module pipeline_perf_monitor
    import pipeline_perf_monitor_pkg::*;
#(
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TRACE_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             ctrl_xfer_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    input  logic             trace_en_i,
    output logic             running_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             ovf_o,
    output logic             rd_valid_o,
    output logic [31:0]      rd_data_o,
    input  logic             rd_ready_i
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
    state_t           state, state_nxt;
    logic             counted, push, full, empty;
    logic [CNT_W-1:0] cyc_nxt;
    assign counted   = start_i && !clear_i && state != DONE;
    assign push      = counted && trace_en_i;
    assign cyc_nxt   = cycle_cnt_o + CNT_W'(counted && ~&cycle_cnt_o);
    assign state_nxt = counted ? (cyc_nxt == MAX_C ? DONE : RUN) : state;
    assign running_o = state == RUN;
    assign done_o    = state == DONE;
    assign rd_valid_o = !empty;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state       <= IDLE;
            cycle_cnt_o <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            ovf_o       <= 1'b0;
        end else if (clear_i) begin
            state       <= IDLE;
            cycle_cnt_o <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            ovf_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cycle_cnt_o <= cyc_nxt;
            stall_cnt_o <= stall_cnt_o + CNT_W'(counted && stall_i && !ctrl_xfer_i && ~&stall_cnt_o);
            flush_cnt_o <= flush_cnt_o + CNT_W'(counted && flush_i && ~&flush_cnt_o);
            // a pop on the same edge frees the slot, so only a pop-less push into a full FIFO is lost
            if (push && full && !rd_ready_i) ovf_o <= 1'b1;
        end
    perf_trace_fifo #(.DEPTH(TRACE_DEPTH), .W(32)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clear_i),
        .push_i  (push),
        .pop_i   (rd_ready_i),
        .din_i   (pc_i),
        .dout_o  (rd_data_o),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb_pipeline_perf_monitor: directed vectors with hand-computed expectations
module tb_pipeline_perf_monitor;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 0, clear = 0, stall = 0, ctrl_xfer = 0, flush = 0, trace_en = 0, rd_ready = 0;
    logic [31:0] pc = '0;
    logic        running, done, ovf, rd_valid;
    logic [15:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [31:0] rd_data;
    int          tests = 0, failed = 0;

    pipeline_perf_monitor dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .stall_i(stall),
        .ctrl_xfer_i(ctrl_xfer), .flush_i(flush), .pc_i(pc), .trace_en_i(trace_en),
        .running_o(running), .done_o(done), .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt), .ovf_o(ovf), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .rd_ready_i(rd_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1;
        step();
        clear = 0;
    endtask

    initial begin
        int n;
        logic [31:0] last;
        #2;
        check("rst_running", running, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        #1 rst = 0;
        step(5);
        check("idle_cycle", cycle_cnt, 0);
        check("idle_running", running, 0);
        check("idle_valid", rd_valid, 0);
        check("idle_done", done, 0);

        start = 1;
        step(29);
        check("run29_cnt", cycle_cnt, 29);
        check("run29_running", running, 1);
        check("run29_done", done, 0);
        step();
        check("run30_cnt", cycle_cnt, 30);
        check("run30_done", done, 1);
        check("run30_running", running, 0);
        step(3);
        check("frozen_cnt", cycle_cnt, 30);
        check("frozen_done", done, 1);
        check("run_stalls", stall_cnt, 0);
        check("run_flushes", flush_cnt, 0);
        check("run_no_trace", rd_valid, 0);

        do_clear();
        check("clr_done", done, 0);
        check("clr_cnt", cycle_cnt, 0);
        start = 1; stall = 1; flush = 1;
        step();
        ctrl_xfer = 1;
        step();
        ctrl_xfer = 0; flush = 0;
        step();
        stall = 0; start = 0;
        check("stall_cnt", stall_cnt, 2);
        check("flush_cnt", flush_cnt, 2);
        check("stall_cycles", cycle_cnt, 3);
        check("stall_running", running, 1);
        step(2);
        check("pause_cnt", cycle_cnt, 3);
        check("pause_running", running, 1);

        do_clear();
        start = 1; trace_en = 1;
        for (int i = 0; i < 10; i++) begin
            pc = 32'(4 * i);
            step();
        end
        start = 0; trace_en = 0;
        check("trace_cycles", cycle_cnt, 10);
        check("trace_ovf", ovf, 1);
        check("trace_valid", rd_valid, 1);
        rd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("trace_rd%0d", i), rd_data, 32'(4 * i));
            step();
        end
        rd_ready = 0;
        check("drained_valid", rd_valid, 0);
        check("drained_data", rd_data, 0);
        check("ovf_sticky", ovf, 1);

        do_clear();
        check("clr_ovf", ovf, 0);
        start = 1; trace_en = 1;
        for (int i = 0; i < 8; i++) begin
            pc = 32'(100 + 4 * i);
            step();
        end
        check("full_no_ovf", ovf, 0);
        pc = 200; rd_ready = 1;
        step();
        start = 0; trace_en = 0; rd_ready = 0;
        check("pushpop_ovf", ovf, 0);
        check("pushpop_head", rd_data, 104);
        n = 0; last = '0; rd_ready = 1;
        for (int i = 0; i < 20 && rd_valid; i++) begin
            last = rd_data;
            n++;
            step();
        end
        rd_ready = 0;
        check("pushpop_occ", n, 8);
        check("pushpop_last", last, 200);

        do_clear();
        start = 1;
        step(5);
        check("pre_rst_cnt", cycle_cnt, 5);
        #1 rst = 1;
        #1;
        check("async_rst_cnt", cycle_cnt, 0);
        check("async_rst_running", running, 0);
        start = 0;
        #1 rst = 0;
        step();
        start = 1;
        step(30);
        check("done_again", done, 1);
        clear = 1;
        step();
        clear = 0; start = 0;
        check("clr_done_state", done, 0);
        check("clr_wins_running", running, 0);
        check("clr_wins_cnt", cycle_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end
endmodule
